// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM register, load/store unit with a req/ready handshake,
// load alignment/extension, store lane replication, and the MEM/WB register.
module memory_stage #(
   parameter int WIDTH    = 32,
   parameter int REG_ADDR = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    ALUResultE,
   input  logic [WIDTH-1:0]    WriteDataE,
   input  logic [WIDTH-1:0]    PCPlus4E,
   input  logic [REG_ADDR-1:0] RdE,
   input  logic                RegWriteE,
   input  logic                MemWriteE,
   input  logic [1:0]          ResultSrcE,
   input  logic [2:0]          Funct3E,
   input  logic                FlushM,
   output logic                mem_req,
   output logic                mem_we,
   output logic [WIDTH-1:0]    mem_addr,
   output logic [WIDTH-1:0]    mem_wdata,
   output logic [3:0]          mem_be,
   input  logic                mem_ready,
   input  logic [WIDTH-1:0]    mem_rdata,
   output logic                StallMemM,
   output logic                MisalignM,
   output logic [WIDTH-1:0]    ALUResultM,
   output logic [REG_ADDR-1:0] RdM,
   output logic                RegWriteM,
   output logic [WIDTH-1:0]    ALUResultW,
   output logic [WIDTH-1:0]    ReadDataW,
   output logic [WIDTH-1:0]    PCPlus4W,
   output logic [REG_ADDR-1:0] RdW,
   output logic                RegWriteW,
   output logic [1:0]          ResultSrcW
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_alu_m, r_wdata_m, r_pc4_m;
   logic [REG_ADDR-1:0] r_rd_m;
   logic                r_regwrite_m, r_memwrite_m;
   logic [1:0]          r_resultsrc_m;
   logic [2:0]          r_funct3_m;

   logic [WIDTH-1:0]    r_alu_w, r_rdata_w, r_pc4_w;
   logic [REG_ADDR-1:0] r_rd_w;
   logic                r_regwrite_w;
   logic [1:0]          r_resultsrc_w;

   logic                w_access, w_misalign, w_req, w_stall;
   logic [3:0]          w_be;
   logic [WIDTH-1:0]    w_wdata, w_load_data;
   logic [7:0]          w_bytes [4];
   logic [7:0]          w_byte;
   logic [15:0]         w_half;

   assign w_access   = r_memwrite_m | (r_resultsrc_m == 2'b01);
   assign w_misalign = w_access &
                       (((r_funct3_m[1:0] == 2'b01) & r_alu_m[0]) |
                        ((r_funct3_m[1:0] == 2'b10) & (|r_alu_m[1:0])));
   // In WAIT the M register is frozen, so the request stays stable until ready.
   assign w_req      = (r_state == S_WAIT) | (w_access & ~w_misalign);
   assign w_stall    = w_req & ~mem_ready;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = r_wdata_m;
      case (r_funct3_m[1:0])
         2'b00: begin
            w_be    = 4'b0001 << r_alu_m[1:0];
            w_wdata = {4{r_wdata_m[7:0]}};
         end
         2'b01: begin
            w_be    = r_alu_m[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wdata_m[15:0]}};
         end
         default: ;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_bytes[gi] = mem_rdata[8*gi +: 8];
      end
   endgenerate

   assign w_byte = w_bytes[r_alu_m[1:0]];
   assign w_half = r_alu_m[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      case (r_funct3_m)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_data = {24'd0, w_byte};
         3'b101:  w_load_data = {16'd0, w_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_alu_m       <= '0;
         r_wdata_m     <= '0;
         r_pc4_m       <= '0;
         r_rd_m        <= '0;
         r_regwrite_m  <= 1'b0;
         r_memwrite_m  <= 1'b0;
         r_resultsrc_m <= 2'b00;
         r_funct3_m    <= 3'b000;
         r_alu_w       <= '0;
         r_rdata_w     <= '0;
         r_pc4_w       <= '0;
         r_rd_w        <= '0;
         r_regwrite_w  <= 1'b0;
         r_resultsrc_w <= 2'b00;
      end else begin
         r_state <= w_stall ? S_WAIT : S_IDLE;

         if (!w_stall) begin
            r_alu_m    <= ALUResultE;
            r_wdata_m  <= WriteDataE;
            r_pc4_m    <= PCPlus4E;
            r_funct3_m <= Funct3E;
            if (FlushM) begin
               r_rd_m        <= '0;
               r_regwrite_m  <= 1'b0;
               r_memwrite_m  <= 1'b0;
               r_resultsrc_m <= 2'b00;
            end else begin
               r_rd_m        <= RdE;
               r_regwrite_m  <= RegWriteE;
               r_memwrite_m  <= MemWriteE;
               r_resultsrc_m <= ResultSrcE;
            end
         end

         // A stalled M stage feeds bubbles into WB so nothing retires twice.
         if (w_stall) begin
            r_alu_w       <= '0;
            r_rdata_w     <= '0;
            r_pc4_w       <= '0;
            r_rd_w        <= '0;
            r_regwrite_w  <= 1'b0;
            r_resultsrc_w <= 2'b00;
         end else begin
            r_alu_w       <= r_alu_m;
            r_rdata_w     <= (w_req & ~r_memwrite_m) ? w_load_data : '0;
            r_pc4_w       <= r_pc4_m;
            r_rd_w        <= r_rd_m;
            r_regwrite_w  <= r_regwrite_m & ~r_memwrite_m & ~w_misalign;
            r_resultsrc_w <= r_resultsrc_m;
         end
      end
   end

   assign mem_req    = w_req;
   assign mem_we     = w_req & r_memwrite_m;
   assign mem_addr   = {r_alu_m[WIDTH-1:2], 2'b00};
   assign mem_wdata  = w_wdata;
   assign mem_be     = w_req ? w_be : 4'b0000;
   assign StallMemM  = w_stall;
   assign MisalignM  = w_misalign;
   assign ALUResultM = r_alu_m;
   assign RdM        = r_rd_m;
   assign RegWriteM  = r_regwrite_m;
   assign ALUResultW = r_alu_w;
   assign ReadDataW  = r_rdata_w;
   assign PCPlus4W   = r_pc4_w;
   assign RdW        = r_rd_w;
   assign RegWriteW  = r_regwrite_w;
   assign ResultSrcW = r_resultsrc_w;

endmodule
